// File: rtl/if_id_pipe_if.sv
// Valid/ready beat carrying a PC and an instruction between pipeline stages.
// The master drives the beat; the slave answers with ready.
interface if_id_pipe_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;

    modport master (output valid, output pc, output inst, input ready);
    modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: main entry plus a one-entry skid buffer, synchronous flush,
// and a saturating count of decode-side stall cycles. Empty entries read as an all-zero NOP.
module if_id_pipe #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    if_id_pipe_if.slave          fetch_io,
    if_id_pipe_if.master         decode_io,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_beat;
    logic   accept;
    logic   pop;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    assign in_beat = {1'b1, fetch_io.pc, fetch_io.inst};

    // Ready depends only on registered skid state, never on decode-side ready.
    assign fetch_io.ready = ~skid_q.valid;
    assign accept         = fetch_io.valid & ~skid_q.valid;
    assign pop            = main_q.valid & decode_io.ready;

    assign decode_io.valid = main_q.valid;
    assign decode_io.pc    = main_q.pc;
    assign decode_io.inst  = main_q.inst;
    assign stall_cnt_o     = stall_cnt_q;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush_i) begin
            main_d = '0;
            skid_d = '0;
        end else if (pop) begin
            if (skid_q.valid) begin
                main_d = skid_q;
                skid_d = '0;
            end else if (accept) begin
                main_d = in_beat;
            end else begin
                main_d = '0;
            end
        end else if (accept) begin
            if (main_q.valid) begin
                skid_d = in_beat;
            end else begin
                main_d = in_beat;
            end
        end
    end

    // Counts stalls even on a flush cycle; saturates instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_q.valid && !decode_io.ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: directed literal checks plus randomized traffic compared every cycle
// against a queue model of the buffered beats.
module tb_if_id_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_pipe_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) f1 ();
    if_id_pipe_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) d1 ();
    if_id_pipe_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) f2 ();
    if_id_pipe_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) d2 ();

    assign f1.valid = if_valid;
    assign f1.pc    = if_pc;
    assign f1.inst  = if_inst;
    assign d1.ready = id_ready;
    assign f2.valid = if_valid;
    assign f2.pc    = if_pc;
    assign f2.inst  = if_inst;
    assign d2.ready = id_ready;

    if_id_pipe #(.ADDR_WIDTH(32), .INST_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .fetch_io   (f1),
        .decode_io  (d1),
        .stall_cnt_o(stall_cnt)
    );

    // Narrow-counter instance sees identical traffic; only its counter is of interest.
    if_id_pipe #(.ADDR_WIDTH(32), .INST_WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .fetch_io   (f2),
        .decode_io  (d2),
        .stall_cnt_o(stall_cnt4)
    );

    // Model: an ordered list of at most two pending beats; the head is what decode sees.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } beat_t;

    beat_t m_q[$];
    int    m_cnt16 = 0;
    int    m_cnt4  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else begin
            bit    can_take;
            beat_t b;
            can_take = (m_q.size() < 2) && if_valid;
            if (m_q.size() > 0 && !id_ready) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
                if (can_take) begin
                    b.pc   = if_pc;
                    b.inst = if_inst;
                    m_q.push_back(b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e_pc, e_inst;
        e_pc   = (m_q.size() > 0) ? m_q[0].pc : 32'h0;
        e_inst = (m_q.size() > 0) ? m_q[0].inst : 32'h0;
        chk("id_valid", 64'(d1.valid), 64'(m_q.size() > 0));
        chk("id_pc", 64'(d1.pc), 64'(e_pc));
        chk("id_inst", 64'(d1.inst), 64'(e_inst));
        chk("if_ready", 64'(f1.ready), 64'(m_q.size() < 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt16));
        chk("stall_cnt4", 64'(stall_cnt4), 64'(m_cnt4));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic rdy);
        chk({name, ".valid"}, 64'(d1.valid), 64'(v));
        chk({name, ".pc"}, 64'(d1.pc), 64'(pc));
        chk({name, ".inst"}, 64'(d1.inst), 64'(inst));
        chk({name, ".ready"}, 64'(f1.ready), 64'(rdy));
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #1;
        chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("reset.cnt", 64'(stall_cnt), 64'd0);
        #22 rst_n = 1'b1;

        // Streaming
        id_ready = 1'b1;
        offer(1'b1, 32'h0, 32'h11);
        tick(); chk_out("stream0", 1'b1, 32'h0, 32'h11, 1'b1);
        offer(1'b1, 32'h4, 32'h22);
        tick(); chk_out("stream1", 1'b1, 32'h4, 32'h22, 1'b1);
        offer(1'b1, 32'h8, 32'h33);
        tick(); chk_out("stream2", 1'b1, 32'h8, 32'h33, 1'b1);
        chk("stream.cnt", 64'(stall_cnt), 64'd0);

        // Back-pressure: C absorbed into skid, 10 held off until skid drains
        id_ready = 1'b0;
        offer(1'b1, 32'hC, 32'h44);
        tick(); chk_out("bp0", 1'b1, 32'h8, 32'h33, 1'b0);
        offer(1'b1, 32'h10, 32'h55);
        tick();
        tick(); chk_out("bp2", 1'b1, 32'h8, 32'h33, 1'b0);
        chk("bp.cnt", 64'(stall_cnt), 64'd3);
        id_ready = 1'b1;
        tick(); chk_out("bp_rel0", 1'b1, 32'hC, 32'h44, 1'b1);
        tick(); chk_out("bp_rel1", 1'b1, 32'h10, 32'h55, 1'b1);

        // Empty output
        offer(1'b0, 32'hDEAD, 32'hBEEF);
        tick(); chk_out("empty0", 1'b0, 32'h0, 32'h0, 1'b1);
        tick(); chk_out("empty1", 1'b0, 32'h0, 32'h0, 1'b1);

        // Flush with both entries full and a beat offered
        id_ready = 1'b0;
        offer(1'b1, 32'h20, 32'h66);
        tick();
        offer(1'b1, 32'h24, 32'h77);
        tick(); chk_out("full", 1'b1, 32'h20, 32'h66, 1'b0);
        flush = 1'b1;
        offer(1'b1, 32'h40, 32'h88);
        tick(); chk_out("flush", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("flush.cnt", 64'(stall_cnt), 64'd5);
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        id_ready = 1'b1;
        tick(); chk_out("post_flush", 1'b0, 32'h0, 32'h0, 1'b1);

        // Asynchronous reset mid-cycle with both entries valid
        id_ready = 1'b0;
        offer(1'b1, 32'h50, 32'h99);
        tick();
        offer(1'b1, 32'h54, 32'hAA);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("async_rst.cnt", 64'(stall_cnt), 64'd0);
        chk("async_rst.cnt4", 64'(stall_cnt4), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Saturation of the 4-bit counter
        offer(1'b1, 32'h60, 32'hBB);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        repeat (20) tick();
        chk("sat.cnt4", 64'(stall_cnt4), 64'd15);
        chk("sat.cnt16", 64'(stall_cnt), 64'd20);
        chk_out("sat", 1'b1, 32'h60, 32'hBB, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            offer(($urandom_range(0, 3) != 0), $urandom, $urandom);
            id_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
